// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register built as a two-entry skid buffer.
// The main entry drives the EX-side payload. The skid entry catches the one
// beat that can arrive while EX is stalled. Because of the skid entry,
// in_ready depends only on registered state and never on out_ready.
// Empty slots read as a NOP bubble with all other payload fields zero.

module id_ex_pipe #(
    parameter int          XLEN     = 64,
    parameter int          CNT_W    = 16,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      inst_i,
    input  logic [XLEN-1:0]  inst_addr_i,
    input  logic [XLEN-1:0]  op1_i,
    input  logic [XLEN-1:0]  op2_i,
    input  logic [4:0]       rd_addr_i,
    input  logic             reg_wen_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst_o,
    output logic [XLEN-1:0]  inst_addr_o,
    output logic [XLEN-1:0]  op1_o,
    output logic [XLEN-1:0]  op2_o,
    output logic [4:0]       rd_addr_o,
    output logic             reg_wen_o,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_BUSY  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam int PW = 32 + 3 * XLEN + 5 + 1;
    localparam logic [PW-1:0] BUBBLE_WORD = {NOP_INST, {(PW - 32){1'b0}}};

    logic [1:0]    state;
    logic [1:0]    state_d;
    logic [PW-1:0] main_q;
    logic [PW-1:0] main_d;
    logic [PW-1:0] skid_q;
    logic [PW-1:0] in_word;
    logic          skid_load;
    logic          in_fire;
    logic          out_fire;

    assign in_word = {inst_i, inst_addr_i, op1_i, op2_i, rd_addr_i, reg_wen_i};
    assign {inst_o, inst_addr_o, op1_o, op2_o, rd_addr_o, reg_wen_o} = main_q;

    assign in_ready  = (state != ST_FULL);
    assign out_valid = (state != ST_EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    // Next-state and next main-entry selection. Flush overrides everything,
    // and an emptied main entry is reloaded with the bubble word.
    always_comb begin
        state_d   = state;
        main_d    = main_q;
        skid_load = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_WORD;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d  = in_word;
                        state_d = ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_word;
                    end else if (out_fire) begin
                        main_d  = BUBBLE_WORD;
                        state_d = ST_EMPTY;
                    end else if (in_fire) begin
                        skid_load = 1'b1;
                        state_d   = ST_FULL;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_d  = skid_q;
                        state_d = ST_BUSY;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_WORD;
                end
            endcase
        end
    end

    // State and main entry registers; reset leaves a bubble on the outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= ST_EMPTY;
            main_q <= BUBBLE_WORD;
        end else begin
            state  <= state_d;
            main_q <= main_d;
        end
    end

    // Skid entry captures the overflow beat; its validity is carried by state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            skid_q <= '0;
        end else if (skid_load) begin
            skid_q <= in_word;
        end
    end

    // Saturating count of edges where EX held off a valid beat; flush does not touch it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
